divisor: RTL and testbench

DIVISOR -- requirements
Module: divisor

---
 rtl/divisor.sv | 38 +++
 tb/tb_divisor.sv | 215 +++++++++++++++++++++
 2 files changed

// File: rtl/divisor.sv
// Clock divider: produces a 50% duty square wave at Frequency from a Reference_Colcck input clock.
// A counter spans one half period; the registered flag toggles each time the counter wraps.
module divisor #(
  parameter int Frequency        = 1_000_000,
  parameter int Reference_Colcck = 50_000_000
) (
  input  logic clk,
  input  logic reset,
  output logic flag
);

  // Half period in input clock cycles; guarded so a zero Frequency reaches the check below.
  localparam int HALF = (Frequency > 0) ? Reference_Colcck / (2 * Frequency) : 0;
  localparam int CW   = (HALF > 1) ? $clog2(HALF) : 1;
  localparam logic [CW-1:0] LAST = CW'(HALF - 1);

  if (Frequency == 0 || HALF < 1) begin : g_bad_params
    $error("divisor: Frequency must be nonzero and at most Reference_Colcck/2");
  end

  logic [CW-1:0] count;

  // Counts above LAST cannot occur in normal operation; they clear without toggling flag.
  always_ff @(posedge clk) begin
    if (reset) begin
      count <= '0;
      flag  <= 1'b0;
    end else if (count == LAST) begin
      count <= '0;
      flag  <= ~flag;
    end else if (count < LAST) begin
      count <= count + CW'(1);
    end else begin
      count <= '0;
    end
  end

endmodule

// File: tb/tb_divisor.sv
// Bench for divisor: three instances (HALF = 25, 1, 8) share clock and reset; expected flags
// come from a closed-form model (toggles = edges_since_reset / HALF) queued per cycle.
`timescale 1ns/1ps
module tb_divisor;

  logic clk;
  logic reset;
  logic flag_main;
  logic flag_h1;
  logic flag_h8;

  int tests;
  int fails;
  int k;

  // Expected flags per cycle, packed as {h8, h1, main}.
  logic [2:0] exp_q[$];

  logic   last_main;
  logic   last_h8;
  int     phase_len;
  logic   phase_valid;
  logic   rise_valid_main;
  logic   rise_valid_h8;
  longint t_rise_main;
  longint t_rise_h8;

  divisor dut_main (
    .clk   (clk),
    .reset (reset),
    .flag  (flag_main)
  );

  divisor #(.Frequency(25_000_000), .Reference_Colcck(50_000_000)) dut_h1 (
    .clk   (clk),
    .reset (reset),
    .flag  (flag_h1)
  );

  divisor #(.Frequency(3_000_000), .Reference_Colcck(50_000_000)) dut_h8 (
    .clk   (clk),
    .reset (reset),
    .flag  (flag_h8)
  );

  // Clock / reset
  initial begin
    clk = 1'b0;
    forever #10 clk = ~clk;
  end

  function automatic logic exp_flag(input int edges, input int half);
    return ((edges / half) % 2) == 1;
  endfunction

  // One clock cycle: drive reset, queue expectation, sample after the edge and score.
  task automatic cycle(input logic rst);
    logic [2:0] exp;
    logic [2:0] got;
    @(negedge clk);
    reset = rst;
    if (rst) exp = 3'b000;
    else exp = {exp_flag(k + 1, 8), exp_flag(k + 1, 1), exp_flag(k + 1, 25)};
    exp_q.push_back(exp);
    @(posedge clk);
    #1;
    if (rst) k = 0;
    else k++;
    got = {flag_h8, flag_h1, flag_main};
    exp = exp_q.pop_front();
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL flags k=%0d rst=%0b: got {h8,h1,main}=%b expected %b", k, rst, got, exp);
    end
    if (rst) begin
      last_main = 1'b0;
      last_h8 = 1'b0;
      phase_len = 0;
      phase_valid = 1'b0;
      rise_valid_main = 1'b0;
      rise_valid_h8 = 1'b0;
    end else begin
      if (got[0] !== last_main) begin
        if (phase_valid) begin
          tests++;
          if (phase_len != 25) begin
            fails++;
            $display("FAIL phase_len k=%0d: got %0d cycles expected 25", k, phase_len);
          end
        end
        phase_valid = 1'b1;
        phase_len = 1;
        if (got[0] === 1'b1) begin
          if (rise_valid_main) begin
            tests++;
            if ($time - t_rise_main != 1000) begin
              fails++;
              $display("FAIL period_main: got %0d ns expected 1000 ns", $time - t_rise_main);
            end
          end
          t_rise_main = $time;
          rise_valid_main = 1'b1;
        end
      end else begin
        phase_len++;
      end
      last_main = got[0];
      if (got[2] === 1'b1 && last_h8 === 1'b0) begin
        if (rise_valid_h8) begin
          tests++;
          if ($time - t_rise_h8 != 320) begin
            fails++;
            $display("FAIL period_h8: got %0d ns expected 320 ns", $time - t_rise_h8);
          end
        end
        t_rise_h8 = $time;
        rise_valid_h8 = 1'b1;
      end
      last_h8 = got[2];
    end
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) cycle(1'b0);
  endtask

  task automatic test_reset();
    cycle(1'b1);
    cycle(1'b1);
    tests++;
    if (dut_main.count !== 5'd0) begin
      fails++;
      $display("FAIL reset_count: got %0d expected 0", dut_main.count);
    end
  endtask

  task automatic test_first_period();
    run(24);
    tests++;
    if (flag_main !== 1'b0) begin
      fails++;
      $display("FAIL edge24_low: got %b expected 0", flag_main);
    end
    run(1);
    tests++;
    if (flag_main !== 1'b1) begin
      fails++;
      $display("FAIL edge25_rise: got %b expected 1", flag_main);
    end
    run(25);
    tests++;
    if (flag_main !== 1'b0) begin
      fails++;
      $display("FAIL edge50_fall: got %b expected 0", flag_main);
    end
  endtask

  task automatic test_long_run();
    run(100 * 50);
  endtask

  task automatic test_reset_mid_period();
    cycle(1'b1);
    run(37);
    tests++;
    if (dut_main.count !== 5'd12 || flag_main !== 1'b1) begin
      fails++;
      $display("FAIL mid_setup: got count=%0d flag=%b expected count=12 flag=1", dut_main.count, flag_main);
    end
    cycle(1'b1);
    tests++;
    if (dut_main.count !== 5'd0 || flag_main !== 1'b0) begin
      fails++;
      $display("FAIL mid_reset: got count=%0d flag=%b expected count=0 flag=0", dut_main.count, flag_main);
    end
    run(24);
    tests++;
    if (flag_main !== 1'b0) begin
      fails++;
      $display("FAIL mid_restart_low: got %b expected 0", flag_main);
    end
    run(1);
    tests++;
    if (flag_main !== 1'b1) begin
      fails++;
      $display("FAIL mid_restart_rise: got %b expected 1", flag_main);
    end
  endtask

  task automatic test_fast_divisors();
    cycle(1'b1);
    run($urandom_range(40, 64));
  endtask

  initial begin
    reset = 1'b1;
    tests = 0;
    fails = 0;
    k = 0;
    test_reset();
    test_first_period();
    test_long_run();
    test_reset_mid_period();
    test_fast_divisors();
    tests++;
    if (exp_q.size() != 0) begin
      fails++;
      $display("FAIL queue_drain: got %0d entries expected 0", exp_q.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
